// File: rtl/instr_fetch_queue_pkg.sv
// Shared widths, reset PC and the fetch-entry payload for the instruction fetch queue.
package instr_fetch_queue_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0]    RESET_PC = 8'h00;
    localparam logic [INSTR_W-1:0] NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_plus1;
    } fetch_entry_t;

    // Word-addressed increment, wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Circular buffer of fetch entries with push, pop and single-cycle flush.
module instr_fetch_queue_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy update; flush wins over push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PTR_W'(1);
            if (pop_i)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (en_i) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (rst && en_i && push_i && !flush_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch engine: owns the fetch PC, issues ROM reads against queue credit and buffers results for decode.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic [PC_W-1:0]    imemAddr,
    input  logic [INSTR_W-1:0] imemData,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirectPC,
    input  logic               deqReady,
    output logic               deqValid,
    output logic [INSTR_W-1:0] deqInstr,
    output logic [PC_W-1:0]    deqPCPlus1,
    output logic [CNT_W-1:0]   count
);

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  last_addr_q, last_addr_d;
    logic [PC_W-1:0]  in_flight_pc_q, in_flight_pc_d;
    logic             in_flight_q, in_flight_d;

    logic             issue_c;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W:0]   occupancy_c;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     head_entry;
    fetch_entry_t     push_entry;

    // Credit counts the in-flight read so a returning word always has a slot.
    assign occupancy_c = {1'b0, fifo_count} + (CNT_W+1)'(in_flight_q);
    assign issue_c     = enable & rst & (redirect | (occupancy_c < (CNT_W+1)'(DEPTH)));

    always_comb begin
        if (!rst)          imemAddr = RESET_PC;
        else if (!enable)  imemAddr = last_addr_q;
        else if (redirect) imemAddr = redirectPC;
        else if (issue_c)  imemAddr = fetch_pc_q;
        else               imemAddr = last_addr_q;
    end

    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        last_addr_d    = last_addr_q;
        in_flight_pc_d = in_flight_pc_q;
        in_flight_d    = 1'b0;
        if (issue_c) begin
            last_addr_d    = imemAddr;
            in_flight_d    = 1'b1;
            in_flight_pc_d = imemAddr;
            fetch_pc_d     = pc_inc(imemAddr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q     <= RESET_PC;
            last_addr_q    <= RESET_PC;
            in_flight_pc_q <= RESET_PC;
            in_flight_q    <= 1'b0;
        end else if (enable) begin
            fetch_pc_q     <= fetch_pc_d;
            last_addr_q    <= last_addr_d;
            in_flight_pc_q <= in_flight_pc_d;
            in_flight_q    <= in_flight_d;
        end
    end

    // A redirect in the return cycle drops the returning word along with the queue.
    assign push_c     = rst & in_flight_q & enable & ~redirect;
    assign pop_c      = deqValid & deqReady & enable & ~redirect;
    assign push_entry = '{instr: imemData, pc_plus1: pc_inc(in_flight_pc_q)};

    instr_fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .en_i        (enable),
        .flush_i     (redirect),
        .push_i      (push_c),
        .push_data_i (push_entry),
        .pop_i       (pop_c),
        .head_o      (head_entry),
        .count_o     (fifo_count)
    );

    assign deqValid   = rst & (fifo_count != '0);
    assign deqInstr   = deqValid ? head_entry.instr : NOP;
    assign deqPCPlus1 = head_entry.pc_plus1;
    assign count      = fifo_count;

endmodule
